uart_tx_fifo: RTL and testbench

Parametrised successor to the single-byte UART transmitter: serialises words from a small internal FIFO onto `tx` with configurable word length, parity and stop bits. Sits between any byte-producing client (command/debug logic) and the board TX pin. Frames are sent back-to-back with no idle gap while the FIFO holds data. `busy` and `overflow` report status.

---
 rtl/uart_pkg.sv | 36 +++
 rtl/uart_sync_fifo.sv | 78 +++++++
 rtl/uart_tx_fifo.sv | 209 ++++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART transmitter and receiver.
//   uart_state_t  : serial-frame FSM states (encoding is fixed and visible
//                   on debug taps, so keep the explicit values).
//   PARITY_*      : parity-mode selector values for the PARITY parameter.
//   parity_bit()  : parity bit for a payload of up to 9 bits.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  localparam int MAX_DATA_BITS = 9;

  // Payloads narrower than 9 bits are zero-extended by the caller, which
  // leaves the ones-count unchanged. Odd mode makes data+parity odd, even
  // mode makes it even.
  function automatic logic parity_bit(input logic [MAX_DATA_BITS-1:0] word,
                                      input int mode);
    logic p;
    if (mode == PARITY_ODD) begin
      p = ~(^word);
    end else begin
      p = ^word;
    end
    return p;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: single-clock FIFO with registered status flags.
//   clk, rst : clock, asynchronous active-high reset (flushes pointers/count)
//   push     : write wdata; ignored while full
//   pop      : advance head; ignored while empty
//   wdata    : write word
//   rdata    : current head word (valid while empty=0)
//   full     : registered, count == DEPTH
//   empty    : registered, count == 0
//   count    : number of stored words
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count_next;
  logic             do_push;
  logic             do_pop;

  // Flags are registered, so a push offered while full is refused even if a
  // pop frees an entry on the same edge.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  // Occupancy after this edge; a simultaneous push and pop leaves it unchanged.
  always_comb begin
    count_next = count;
    case ({do_push, do_pop})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
  end

  // Storage array; contents need no reset because pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers, count and status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count_next;
      full  <= (count_next == CW'(DEPTH));
      empty <= (count_next == '0);
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: FIFO-buffered UART transmitter with configurable word
// length, parity and stop bits. Frames are sent back-to-back while words
// are queued.
//   clk, rst   : clock, asynchronous active-high reset (abandons any frame)
//   start      : write strobe, pushes data when ready=1
//   data       : word to send, LSB first
//   ready      : FIFO not full (registered)
//   tx         : serial line, idle high, driven from a register
//   busy       : transmitter FSM not idle (registered)
//   fifo_count : words waiting in the FIFO
//   overflow   : sticky, start seen while ready=0; cleared only by reset
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4,
  localparam int CW = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [DATA_BITS-1:0] data,
  output logic                 ready,
  output logic                 tx,
  output logic                 busy,
  output logic [CW-1:0]        fifo_count,
  output logic                 overflow
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = $clog2(DATA_BITS);

  uart_state_t          state;
  uart_state_t          state_next;
  logic [BAUD_W-1:0]    baud_cnt;
  logic [BAUD_W-1:0]    baud_next;
  logic [BIT_W-1:0]     bit_cnt;
  logic [BIT_W-1:0]     bit_next;
  logic                 stop_cnt;
  logic                 stop_next;
  logic [DATA_BITS-1:0] shift;
  logic [DATA_BITS-1:0] shift_next;
  logic                 parity;
  logic                 parity_next;
  logic                 tx_next;
  logic                 pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [DATA_BITS-1:0] fifo_rdata;
  logic                 baud_last;
  logic                 stop_last;

  uart_sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (start),
    .pop   (pop),
    .wdata (data),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign ready     = ~fifo_full;
  assign baud_last = (baud_cnt == BAUD_W'(CLKS_PER_BIT - 1));
  assign stop_last = (STOP_BITS == 1) ? 1'b1 : stop_cnt;

  // Next-state, shifter and next tx level. tx is computed one cycle ahead so
  // the line itself comes straight from a flop.
  always_comb begin
    state_next  = state;
    baud_next   = baud_cnt;
    bit_next    = bit_cnt;
    stop_next   = stop_cnt;
    shift_next  = shift;
    parity_next = parity;
    tx_next     = tx;
    pop         = 1'b0;

    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop         = 1'b1;
          shift_next  = fifo_rdata;
          parity_next = parity_bit(MAX_DATA_BITS'(fifo_rdata), PARITY);
          baud_next   = '0;
          state_next  = ST_START;
          tx_next     = 1'b0;
        end else begin
          tx_next     = 1'b1;
        end
      end

      ST_START: begin
        if (baud_last) begin
          baud_next  = '0;
          bit_next   = '0;
          state_next = ST_DATA;
          tx_next    = shift[0];
        end else begin
          baud_next  = baud_cnt + BAUD_W'(1);
          tx_next    = 1'b0;
        end
      end

      ST_DATA: begin
        if (baud_last) begin
          baud_next = '0;
          if (bit_cnt == BIT_W'(DATA_BITS - 1)) begin
            bit_next = '0;
            if (PARITY != PARITY_NONE) begin
              state_next = ST_PARITY;
              tx_next    = parity;
            end else begin
              state_next = ST_STOP;
              stop_next  = 1'b0;
              tx_next    = 1'b1;
            end
          end else begin
            bit_next   = bit_cnt + BIT_W'(1);
            shift_next = shift >> 1;
            // shift[1] is the bit that becomes the LSB after this shift.
            tx_next    = shift[1];
          end
        end else begin
          baud_next = baud_cnt + BAUD_W'(1);
        end
      end

      ST_PARITY: begin
        if (baud_last) begin
          baud_next  = '0;
          stop_next  = 1'b0;
          state_next = ST_STOP;
          tx_next    = 1'b1;
        end else begin
          baud_next  = baud_cnt + BAUD_W'(1);
        end
      end

      ST_STOP: begin
        if (baud_last) begin
          baud_next = '0;
          if (stop_last) begin
            // Chain straight into the next start bit when data is waiting.
            if (!fifo_empty) begin
              pop         = 1'b1;
              shift_next  = fifo_rdata;
              parity_next = parity_bit(MAX_DATA_BITS'(fifo_rdata), PARITY);
              state_next  = ST_START;
              tx_next     = 1'b0;
            end else begin
              state_next  = ST_IDLE;
              tx_next     = 1'b1;
            end
          end else begin
            stop_next = 1'b1;
            tx_next   = 1'b1;
          end
        end else begin
          baud_next = baud_cnt + BAUD_W'(1);
        end
      end

      default: begin
        state_next = ST_IDLE;
        baud_next  = '0;
        bit_next   = '0;
        stop_next  = 1'b0;
        tx_next    = 1'b1;
      end
    endcase
  end

  // FSM, counters, shifter and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      shift    <= '0;
      parity   <= 1'b0;
      tx       <= 1'b1;
      busy     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state    <= state_next;
      baud_cnt <= baud_next;
      bit_cnt  <= bit_next;
      stop_cnt <= stop_next;
      shift    <= shift_next;
      parity   <= parity_next;
      tx       <= tx_next;
      busy     <= (state_next != ST_IDLE);
      if (start && !ready) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo with four configurations: 8N1, 8E1, 8O1 and 7N2,
// all with CLKS_PER_BIT=4 and FIFO_DEPTH=4.
module tb_uart_tx_fifo;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] start_v;
  logic [7:0] din;
  logic [3:0] tx_v;
  logic [3:0] busy_v;
  logic [3:0] ready_v;
  logic [3:0] ovf_v;
  logic [2:0] cnt0, cnt1, cnt2, cnt3;

  always #5 clk = ~clk;

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_8n1 (
    .clk(clk), .rst(rst), .start(start_v[0]), .data(din), .ready(ready_v[0]),
    .tx(tx_v[0]), .busy(busy_v[0]), .fifo_count(cnt0), .overflow(ovf_v[0]));

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_8e1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .data(din), .ready(ready_v[1]),
    .tx(tx_v[1]), .busy(busy_v[1]), .fifo_count(cnt1), .overflow(ovf_v[1]));

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_8o1 (
    .clk(clk), .rst(rst), .start(start_v[2]), .data(din), .ready(ready_v[2]),
    .tx(tx_v[2]), .busy(busy_v[2]), .fifo_count(cnt2), .overflow(ovf_v[2]));

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4)) dut_7n2 (
    .clk(clk), .rst(rst), .start(start_v[3]), .data(din[6:0]), .ready(ready_v[3]),
    .tx(tx_v[3]), .busy(busy_v[3]), .fifo_count(cnt3), .overflow(ovf_v[3]));

  typedef struct packed {
    logic       tx;
    logic       busy;
    logic       ready;
    logic       ovf;
    logic [2:0] cnt;
  } smp_t;

  // Directed frame vector: frame bit j is the j-th serial bit on the line.
  typedef struct {
    int         sel;
    logic [7:0] word;
    logic [11:0] frame;
    int         len;
    string      name;
  } vec_t;

  vec_t       vecs[10];
  smp_t       q[$];
  logic       exp_q[$];
  logic [7:0] words[8];
  int         nwords;
  int         sel = 0;
  logic       rec = 1'b0;
  int         errors = 0;
  int         checks = 0;

  function automatic smp_t cur_sample();
    smp_t s;
    s.tx    = tx_v[sel];
    s.busy  = busy_v[sel];
    s.ready = ready_v[sel];
    s.ovf   = ovf_v[sel];
    case (sel)
      0:       s.cnt = cnt0;
      1:       s.cnt = cnt1;
      2:       s.cnt = cnt2;
      default: s.cnt = cnt3;
    endcase
    return s;
  endfunction

  // One sample per clock, 1 time unit after the rising edge.
  always @(posedge clk) begin
    #1;
    if (rec) q.push_back(cur_sample());
  end

  task automatic check(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  // Push words[0..nwords-1] into the selected DUT on consecutive edges.
  // Recording starts so that sample 0 is the state after the first push edge.
  task automatic push_words();
    @(negedge clk);
    q.delete();
    rec = 1'b1;
    for (int k = 0; k < nwords; k++) begin
      start_v      = 4'b0000;
      start_v[sel] = 1'b1;
      din          = words[k];
      @(negedge clk);
    end
    start_v = 4'b0000;
  endtask

  task automatic add_frame(input logic [11:0] frame, input int len);
    for (int j = 0; j < len; j++)
      for (int c = 0; c < CPB; c++) exp_q.push_back(frame[j]);
  endtask

  task automatic collect(input int n);
    for (int c = 0; c < n + 50 && q.size() < n; c++) @(negedge clk);
    rec = 1'b0;
    check("collect_samples", n, 8'(q.size() >= n), 8'd1);
  endtask

  // Sample 0 idle, samples 1..N follow exp_q with busy high, the rest idle.
  task automatic check_stream(input string name);
    int n;
    n = exp_q.size();
    if (q.size() >= n + 2) begin
      check({name, "_pre"}, 0, {6'd0, q[0].tx, q[0].busy}, 8'b10);
      for (int i = 0; i < n; i++)
        check({name, "_bit"}, i, {6'd0, q[i+1].tx, q[i+1].busy}, {6'd0, exp_q[i], 1'b1});
      for (int i = n + 1; i < q.size(); i++)
        check({name, "_post"}, i, {6'd0, q[i].tx, q[i].busy}, 8'b10);
    end
  endtask

  initial begin
    // 8N1: start, LSB-first data, stop
    vecs[0] = '{0, 8'h41, 12'h282, 10, "8n1_41"};
    vecs[1] = '{0, 8'h00, 12'h200, 10, "8n1_00"};
    vecs[2] = '{0, 8'hFF, 12'h3FE, 10, "8n1_ff"};
    vecs[3] = '{0, 8'hA5, 12'h34A, 10, "8n1_a5"};
    // 8E1 / 8O1: parity at bit 9, stop at bit 10
    vecs[4] = '{1, 8'h41, 12'h482, 11, "8e1_41"};
    vecs[5] = '{1, 8'h07, 12'h60E, 11, "8e1_07"};
    vecs[6] = '{2, 8'h41, 12'h682, 11, "8o1_41"};
    vecs[7] = '{2, 8'h07, 12'h40E, 11, "8o1_07"};
    // 7N2: two stop bits at 8 and 9
    vecs[8] = '{3, 8'h7F, 12'h3FE, 10, "7n2_7f"};
    vecs[9] = '{3, 8'h2A, 12'h354, 10, "7n2_2a"};

    rst     = 1'b1;
    start_v = 4'b0000;
    din     = 8'h00;
    #1;
    check("reset_tx_all", 0, {4'd0, tx_v}, 8'h0F);
    check("reset_busy",   0, {4'd0, busy_v}, 8'h00);
    check("reset_ready",  0, {4'd0, ready_v}, 8'h0F);
    check("reset_ovf",    0, {4'd0, ovf_v}, 8'h00);
    check("reset_count",  0, {5'd0, cnt0}, 8'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Single frames from the table.
    for (int v = 0; v < 10; v++) begin
      sel      = vecs[v].sel;
      words[0] = vecs[v].word;
      nwords   = 1;
      exp_q.delete();
      add_frame(vecs[v].frame, vecs[v].len);
      push_words();
      collect(exp_q.size() + 2);
      check_stream(vecs[v].name);
      check({vecs[v].name, "_cnt"}, 0, {5'd0, q[0].cnt}, 8'd1);
      check({vecs[v].name, "_cnt"}, 1, {5'd0, q[1].cnt}, 8'd0);
    end

    // Three back-to-back frames with no idle gap.
    sel = 0;
    words[0] = 8'h55; words[1] = 8'hAA; words[2] = 8'h0F;
    nwords = 3;
    exp_q.delete();
    add_frame(12'h2AA, 10);
    add_frame(12'h354, 10);
    add_frame(12'h21E, 10);
    push_words();
    collect(exp_q.size() + 2);
    check_stream("b2b");
    check("b2b_cnt", 1,  {5'd0, q[1].cnt},  8'd1);
    check("b2b_cnt", 2,  {5'd0, q[2].cnt},  8'd2);
    check("b2b_cnt", 41, {5'd0, q[41].cnt}, 8'd1);
    check("b2b_cnt", 81, {5'd0, q[81].cnt}, 8'd0);

    // Six pushes into a depth-4 FIFO: fifth fills it, sixth overflows.
    sel = 0;
    for (int k = 0; k < 6; k++) words[k] = 8'(k + 1);
    nwords = 6;
    exp_q.delete();
    add_frame(12'h202, 10);
    add_frame(12'h204, 10);
    add_frame(12'h206, 10);
    add_frame(12'h208, 10);
    add_frame(12'h20A, 10);
    push_words();
    collect(exp_q.size() + 2 + 40);
    check_stream("ovf");
    check("ovf_ready3", 3, {7'd0, q[3].ready}, 8'd1);
    check("ovf_cnt3",   3, {5'd0, q[3].cnt},   8'd3);
    check("ovf_ready4", 4, {7'd0, q[4].ready}, 8'd0);
    check("ovf_cnt4",   4, {5'd0, q[4].cnt},   8'd4);
    check("ovf_flag4",  4, {7'd0, q[4].ovf},   8'd0);
    check("ovf_flag5",  5, {7'd0, q[5].ovf},   8'd1);
    check("ovf_cnt5",   5, {5'd0, q[5].cnt},   8'd4);
    check("ovf_ready45", 45, {7'd0, q[45].ready}, 8'd1);
    check("ovf_sticky", 241, {7'd0, q[241].ovf}, 8'd1);

    // Reset in the middle of data bit 3 with two words still queued.
    sel = 0;
    words[0] = 8'h00; words[1] = 8'h00; words[2] = 8'h00;
    nwords = 3;
    push_words();
    collect(19);
    check("rst_pre_tx",  18, {7'd0, q[18].tx},  8'd0);
    check("rst_pre_cnt", 18, {5'd0, q[18].cnt}, 8'd2);
    #2 rst = 1'b1;
    #1;
    check("rst_async_tx",   0, {7'd0, tx_v[0]},    8'd1);
    check("rst_async_cnt",  0, {5'd0, cnt0},       8'd0);
    check("rst_async_busy", 0, {7'd0, busy_v[0]},  8'd0);
    check("rst_async_rdy",  0, {7'd0, ready_v[0]}, 8'd1);
    check("rst_async_ovf",  0, {7'd0, ovf_v[0]},   8'd0);
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    rec = 1'b1;
    repeat (60) @(negedge clk);
    rec = 1'b0;
    check("rst_samples", 0, 8'(q.size() >= 59), 8'd1);
    for (int i = 0; i < q.size(); i++)
      check("rst_quiet", i, {q[i].tx, q[i].busy, 3'd0, q[i].cnt}, 8'h80);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
